// File: rtl/wb_regfile_if.sv
// Bus bundle between the EX/WB stage, the ID operand fetch and the architectural register file.
// The master drives WB commit, read and debug requests. The slave is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    localparam int NREGS = 2**ADDR_W;

    logic              wb_valid;
    logic [7:0]        wb_pc;
    logic              wb_reg_write;
    logic [ADDR_W-1:0] wb_write_reg;
    logic [DATA_W-1:0] wb_result;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              sb_clear;
    logic [NREGS-1:0]  written_map;
    logic [CNT_W-1:0]  retire_count;
    logic [7:0]        last_pc;
    logic              commit_pulse;

    modport master (
        output wb_valid, wb_pc, wb_reg_write, wb_write_reg, wb_result,
               rs1_addr, rs2_addr, dbg_addr, sb_clear,
        input  rs1_data, rs2_data, dbg_data, written_map, retire_count, last_pc, commit_pulse
    );

    modport slave (
        input  wb_valid, wb_pc, wb_reg_write, wb_write_reg, wb_result,
               rs1_addr, rs2_addr, dbg_addr, sb_clear,
        output rs1_data, rs2_data, dbg_data, written_map, retire_count, last_pc, commit_pulse
    );
endinterface

// File: rtl/wb_regfile.sv
// This is the architectural register file of the 4-stage 8-bit pipeline. It has two bypassed read ports,
// a registered debug read, and retire bookkeeping (retire count, last PC, written-register map).
module wb_regfile #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int CNT_W   = 16,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] r_regs;
    logic [DATA_W-1:0]            r_dbg;
    logic [NREGS-1:0]             r_map;
    logic [CNT_W-1:0]             r_cnt;
    logic [7:0]                   r_pc;
    logic                         r_pulse;

    logic w_wr_r0;
    logic w_commit;

    assign w_wr_r0  = ZERO_R0 && (bus.wb_write_reg == '0);
    assign w_commit = bus.wb_valid && bus.wb_reg_write && !w_wr_r0;

    // A suppressed commit to a hard-wired R0 must not forward either. So the bypass uses w_commit.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        if (ZERO_R0 && a == '0)
            return '0;
        else if (w_commit && bus.wb_write_reg == a)
            return bus.wb_result;
        else
            return r_regs[a];
    endfunction

    always_comb begin
        bus.rs1_data = rd(bus.rs1_addr);
        bus.rs2_data = rd(bus.rs2_addr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs  <= '0;
            r_dbg   <= '0;
            r_map   <= '0;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_pulse <= 1'b0;
        end else begin
            if (w_commit)
                r_regs[bus.wb_write_reg] <= bus.wb_result;
            r_dbg <= r_regs[bus.dbg_addr];
            // When a commit happens in the same cycle as a clear, the commit's bit survives the clear.
            if (bus.sb_clear)
                r_map <= w_commit ? (NREGS'(1) << bus.wb_write_reg) : '0;
            else if (w_commit)
                r_map[bus.wb_write_reg] <= 1'b1;
            if (bus.wb_valid) begin
                if (r_cnt != '1)
                    r_cnt <= r_cnt + 1'b1;
                r_pc <= bus.wb_pc;
            end
            r_pulse <= w_commit;
        end
    end

    assign bus.dbg_data     = r_dbg;
    assign bus.written_map  = r_map;
    assign bus.retire_count = r_cnt;
    assign bus.last_pc      = r_pc;
    assign bus.commit_pulse = r_pulse;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile. Expected registered outputs are queued as each cycle is driven.
// They are popped and compared once the clock edge has produced them.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) bus ();

    wb_regfile #(.DATA_W(8), .ADDR_W(3), .CNT_W(16), .ZERO_R0(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]  dbg;
        logic [7:0]  map;
        logic [15:0] cnt;
        logic [7:0]  pc;
        logic        pulse;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  m_regs [8];
    logic [7:0]  m_map;
    logic [15:0] m_cnt;
    logic [7:0]  m_pc;
    int          checks = 0;
    int          failures = 0;

    function automatic exp_t observed();
        exp_t o;
        o.dbg   = bus.dbg_data;
        o.map   = bus.written_map;
        o.cnt   = bus.retire_count;
        o.pc    = bus.last_pc;
        o.pulse = bus.commit_pulse;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_map = 8'h00;
        m_cnt = 16'h0000;
        m_pc  = 8'h00;
        q.delete();
    endtask

    // Drive one WB cycle. Queue what the registered outputs must show after the next edge.
    task automatic drive(input logic v, input logic [7:0] pc, input logic rw, input logic [2:0] wr,
                         input logic [7:0] res, input logic [2:0] da, input logic clr);
        exp_t e;
        logic c;
        bus.wb_valid = v; bus.wb_pc = pc; bus.wb_reg_write = rw; bus.wb_write_reg = wr;
        bus.wb_result = res; bus.dbg_addr = da; bus.sb_clear = clr;
        c = v && rw && (wr != 3'd0);
        e.dbg = m_regs[da];
        if (c) m_regs[wr] = res;
        if (clr) m_map = 8'h00;
        if (c) m_map[wr] = 1'b1;
        if (v) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_pc = pc;
        end
        e.map = m_map; e.cnt = m_cnt; e.pc = m_pc; e.pulse = c;
        q.push_back(e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid = 0; bus.wb_reg_write = 0; bus.sb_clear = 0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int i = 1; i < 8; i++) begin
            drive(1, 8'(i), 1, 3'(i), 8'(8'h10 * i + 1), 3'(i), 0);
            tick();
            e = q.pop_front(); o = observed(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset_prefill r%0d got=%h exp=%h", i, o, e); end
        end
        idle();
        #2 reset = 1'b0;
        #1;
        model_reset();
        o = observed(); checks++;
        if (o !== '0) begin failures++; $display("FAIL reset_async_outputs got=%h exp=0", o); end
        for (int i = 1; i < 8; i++) begin
            bus.rs1_addr = 3'(i); bus.rs2_addr = 3'(i); #1;
            checks++;
            if (bus.rs1_data !== 8'h00 || bus.rs2_data !== 8'h00) begin
                failures++; $display("FAIL reset_read r%0d got=%h/%h exp=00", i, bus.rs1_data, bus.rs2_data);
            end
        end
        @(negedge clk) reset = 1'b1;
        tick();
    endtask

    task automatic test_commit();
        exp_t e, o;
        drive(1, 8'h10, 1, 3'd3, 8'hA5, 3'd0, 0);
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e || o.map !== 8'h08 || o.pulse !== 1'b1) begin
            failures++; $display("FAIL commit_r3 got=%h exp=%h", o, e);
        end
        idle(); bus.rs1_addr = 3'd3; #1;
        checks++;
        if (bus.rs1_data !== 8'hA5) begin failures++; $display("FAIL commit_read got=%h exp=a5", bus.rs1_data); end
    endtask

    task automatic test_bypass();
        exp_t e, o;
        drive(1, 8'h20, 1, 3'd5, 8'h11, 3'd0, 0);
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL bypass_pre got=%h exp=%h", o, e); end
        bus.rs1_addr = 3'd5; bus.rs2_addr = 3'd5;
        drive(1, 8'h21, 1, 3'd5, 8'h3C, 3'd5, 0);
        checks++;
        if (bus.rs1_data !== 8'h3C || bus.rs2_data !== 8'h3C) begin
            failures++; $display("FAIL bypass_both got=%h/%h exp=3c", bus.rs1_data, bus.rs2_data);
        end
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e || o.dbg !== 8'h11) begin failures++; $display("FAIL bypass_dbg_old got=%h exp=%h", o, e); end
        drive(0, 8'h00, 0, 3'd0, 8'h00, 3'd5, 0);
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e || o.dbg !== 8'h3C) begin failures++; $display("FAIL bypass_dbg_new got=%h exp=%h", o, e); end
    endtask

    task automatic test_zero_r0();
        exp_t e, o;
        logic [15:0] cnt0;
        cnt0 = m_cnt;
        bus.rs1_addr = 3'd0;
        drive(1, 8'h40, 1, 3'd0, 8'hFF, 3'd0, 0);
        checks++;
        if (bus.rs1_data !== 8'h00) begin failures++; $display("FAIL r0_no_bypass got=%h exp=00", bus.rs1_data); end
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e || o.map[0] !== 1'b0 || o.pulse !== 1'b0 || o.pc !== 8'h40 || o.cnt !== cnt0 + 16'd1) begin
            failures++; $display("FAIL r0_commit got=%h exp=%h", o, e);
        end
        idle(); #1;
        checks++;
        if (bus.rs1_data !== 8'h00) begin failures++; $display("FAIL r0_read got=%h exp=00", bus.rs1_data); end
    endtask

    task automatic test_bubble();
        exp_t e, o;
        drive(1, 8'h50, 1, 3'd2, 8'h22, 3'd0, 0);
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL bubble_pre got=%h exp=%h", o, e); end
        bus.rs1_addr = 3'd2;
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h99, 1, 3'd2, 8'h77, 3'd2, 0);
            checks++;
            if (bus.rs1_data !== 8'h22) begin failures++; $display("FAIL bubble_nobypass got=%h exp=22", bus.rs1_data); end
            tick();
            e = q.pop_front(); o = observed(); checks++;
            if (o !== e || o.pc !== 8'h50) begin failures++; $display("FAIL bubble_%0d got=%h exp=%h", i, o, e); end
        end
        idle();
    endtask

    task automatic test_sb_clear();
        exp_t e, o;
        drive(1, 8'h60, 1, 3'd6, 8'h66, 3'd0, 1);
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e || o.map !== 8'h40) begin failures++; $display("FAIL sbclear_commit got=%h exp=%h", o, e); end
        drive(0, 8'h00, 0, 3'd0, 8'h00, 3'd0, 1);
        tick();
        e = q.pop_front(); o = observed(); checks++;
        if (o !== e || o.map !== 8'h00) begin failures++; $display("FAIL sbclear_only got=%h exp=%h", o, e); end
        idle();
    endtask

    task automatic test_saturate();
        exp_t e, o;
        int n;
        n = 16'hFFFE - int'(m_cnt);
        bus.wb_valid = 1; bus.wb_pc = 8'h70; bus.wb_reg_write = 0; bus.sb_clear = 0;
        repeat (n) @(posedge clk);
        #1;
        idle();
        m_cnt = 16'hFFFE; m_pc = 8'h70;
        checks++;
        if (bus.retire_count !== 16'hFFFE) begin
            failures++; $display("FAIL sat_preload got=%h exp=fffe", bus.retire_count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h80 + i), 0, 3'd0, 8'h00, 3'd0, 0);
            tick();
            e = q.pop_front(); o = observed(); checks++;
            if (o !== e || o.cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_%0d got=%h exp=%h", i, o, e); end
        end
        idle();
    endtask

    initial begin
        bus.wb_valid = 0; bus.wb_pc = 0; bus.wb_reg_write = 0; bus.wb_write_reg = 0;
        bus.wb_result = 0; bus.rs1_addr = 0; bus.rs2_addr = 0; bus.dbg_addr = 0; bus.sb_clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== '0) begin failures++; $display("FAIL reset_initial got=%h exp=0", observed()); end
        @(negedge clk) reset = 1'b1;
        tick();
        test_reset();
        test_commit();
        test_bypass();
        test_zero_r0();
        test_bubble();
        test_sb_clear();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
